conv_seq_ctrl: RTL and testbench

// Sequencer for the 1-D convolution datapath (X memory, F ROM, MAC accumulator, output AXI-style port).
// It waits for a full X buffer, then computes each of the N-M+1 outputs in turn.
// For every output it issues M (x_addr, f_addr) read pairs and drives the accumulator clear/enable aligned to the MAC pipeline.
// It presents each result on a valid/ready handshake and pulses done so the X buffer can be refilled.

---
 rtl/conv_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_conv_seq_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the 1-D convolution datapath: walks every output position,
// issues the X/F read pairs, aligns accumulator control to the MAC pipeline.
module conv_seq_ctrl #(
   parameter int N       = 16,
   parameter int M       = 4,
   parameter int MAC_LAT = 2,
   parameter int XW      = $clog2(N),
   parameter int FW      = $clog2(M)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_i,
   output logic          rd_en_o,
   output logic [XW-1:0] x_addr_o,
   output logic [FW-1:0] f_addr_o,
   output logic          clr_acc_o,
   output logic          acc_en_o,
   output logic          m_valid_y_o,
   input  logic          m_ready_y_i,
   output logic          done_o
);

   localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [XW-1:0] LAST_J = XW'(N - M);
   localparam logic [FW-1:0] LAST_K = FW'(M - 1);
   localparam logic [DW-1:0] LAST_D = DW'(MAC_LAT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      DRAIN,
      OUT,
      DONE
   } state_e;

   state_e             state_q, state_d;
   logic [XW-1:0]      j_q, j_d;
   logic [FW-1:0]      k_q, k_d;
   logic [DW-1:0]      d_q, d_d;
   logic [MAC_LAT-1:0] rdPipe_q;
   logic [MAC_LAT-1:0] clrPipe_q;
   logic               issue;
   logic               issueFirst;

   assign issue      = (state_q == ISSUE);
   assign issueFirst = issue && (k_q == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         j_q     <= '0;
         k_q     <= '0;
         d_q     <= '0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         k_q     <= k_d;
         d_q     <= d_d;
      end
   end

   // The drain phase lets the last product of an output reach the
   // accumulator before the result is offered downstream.
   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      k_d     = k_q;
      d_d     = d_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = ISSUE;
               j_d     = '0;
               k_d     = '0;
            end
         end
         ISSUE: begin
            if (k_q == LAST_K) begin
               state_d = DRAIN;
               k_d     = '0;
               d_d     = '0;
            end else begin
               k_d = k_q + FW'(1);
            end
         end
         DRAIN: begin
            if (d_q == LAST_D) begin
               state_d = OUT;
            end else begin
               d_d = d_q + DW'(1);
            end
         end
         OUT: begin
            if (m_ready_y_i) begin
               if (j_q == LAST_J) begin
                  state_d = DONE;
               end else begin
                  j_d     = j_q + XW'(1);
                  state_d = ISSUE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            j_d     = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Delay lines matching the memory + multiplier latency; cleared on reset
   // so an aborted run leaves no stray accumulator updates behind.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdPipe_q  <= '0;
         clrPipe_q <= '0;
      end else begin
         rdPipe_q  <= (rdPipe_q << 1) | MAC_LAT'(issue);
         clrPipe_q <= (clrPipe_q << 1) | MAC_LAT'(issueFirst);
      end
   end

   assign rd_en_o     = issue;
   assign x_addr_o    = j_q + XW'(k_q);
   assign f_addr_o    = k_q;
   assign acc_en_o    = rdPipe_q[MAC_LAT-1];
   assign clr_acc_o   = clrPipe_q[MAC_LAT-1];
   assign m_valid_y_o = (state_q == OUT);
   assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: a time-offset reference model of the
// convolution schedule plus explicit timing checks; a second instance sweeps parameters.
module tb_conv_seq_ctrl;

   localparam int N = 16;
   localparam int M = 4;
   localparam int L = 2;

   logic       clk = 1'b0;
   logic       reset, start, mReady;
   logic       rd, clr, acc, valid, done;
   logic [3:0] xa;
   logic [1:0] fa;

   logic       reset2, start2, ready2;
   logic       rd2, clr2, acc2, valid2, done2;
   logic [2:0] xa2, fa2;

   int total = 0;
   int bad   = 0;

   // Reference model: output index, cycles elapsed inside that output, and
   // the history of issued reads used to predict accumulator activity.
   bit         mRun  = 1'b0;
   bit         mDone = 1'b0;
   int         mJ    = 0;
   int         mT    = 0;
   bit [L-1:0] hRd   = '0;
   bit [L-1:0] hClr  = '0;

   always #5 clk = ~clk;

   conv_seq_ctrl #(.N(N), .M(M), .MAC_LAT(L)) dut (
      .clk(clk), .reset(reset), .start_i(start),
      .rd_en_o(rd), .x_addr_o(xa), .f_addr_o(fa),
      .clr_acc_o(clr), .acc_en_o(acc),
      .m_valid_y_o(valid), .m_ready_y_i(mReady), .done_o(done)
   );

   conv_seq_ctrl #(.N(8), .M(8), .MAC_LAT(1)) dut2 (
      .clk(clk), .reset(reset2), .start_i(start2),
      .rd_en_o(rd2), .x_addr_o(xa2), .f_addr_o(fa2),
      .clr_acc_o(clr2), .acc_en_o(acc2),
      .m_valid_y_o(valid2), .m_ready_y_i(ready2), .done_o(done2)
   );

   function automatic logic [10:0] expVec();
      logic       rdE;
      logic [3:0] xE;
      logic [1:0] fE;
      rdE = mRun && (mT < M);
      xE  = rdE ? 4'(mJ + mT) : 4'd0;
      fE  = rdE ? 2'(mT) : 2'd0;
      return {rdE, hRd[L-1], hClr[L-1], mRun && (mT >= M + L), mDone, xE, fE};
   endfunction

   function automatic logic [10:0] obsVec();
      return {rd, acc, clr, valid, done, rd ? xa : 4'd0, rd ? fa : 2'd0};
   endfunction

   // Advance the model with the inputs the DUT will see at the next edge,
   // then move to the following falling edge for sampling.
   task automatic tick();
      bit rdNow, clrNow, vNow;
      rdNow = mRun && (mT < M);
      clrNow = rdNow && (mT == 0);
      vNow = mRun && (mT >= M + L);
      hRd  = (hRd << 1) | L'(rdNow);
      hClr = (hClr << 1) | L'(clrNow);
      if (reset) begin
         mRun = 1'b0; mDone = 1'b0; hRd = '0; hClr = '0;
      end else if (mDone) begin
         mDone = 1'b0;
      end else if (!mRun) begin
         if (start) begin mRun = 1'b1; mJ = 0; mT = 0; end
      end else if (vNow) begin
         if (mReady) begin
            if (mJ == N - M) begin mRun = 1'b0; mDone = 1'b1; end
            else begin mJ++; mT = 0; end
         end
      end else begin
         mT++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; mReady = 1'b0;
      reset2 = 1'b1; start2 = 1'b0; ready2 = 1'b0;
      tick(); tick();
      total++;
      if ({rd, xa, fa, clr, acc, valid, done} !== 11'd0) begin
         bad++; $display("[TB] FAIL reset_outputs got=%b want=0", {rd, xa, fa, clr, acc, valid, done});
      end
      reset = 1'b1; start = 1'b1;
      tick();
      total++;
      if ({rd, xa, fa, clr, acc, valid, done} !== 11'd0) begin
         bad++; $display("[TB] FAIL reset_over_start got=%b want=0", {rd, xa, fa, clr, acc, valid, done});
      end
      reset = 1'b0; start = 1'b0;
      tick();
      total++;
      if (obsVec() !== expVec()) begin
         bad++; $display("[TB] FAIL idle_after_reset got=%b want=%b", obsVec(), expVec());
      end
   endtask

   task automatic test_full_run();
      int c, hs, dn, doneC, firstHs, lastHs, spacingErr;
      logic eRd, eAcc, eClr, eV;
      logic [10:0] ex;
      hs = 0; dn = 0; doneC = 0; firstHs = 0; lastHs = 0; spacingErr = 0;
      start = 1'b1; mReady = 1'b1;
      tick();
      start = 1'b0;
      for (c = 1; c <= 95; c++) begin
         total++;
         if (obsVec() !== expVec()) begin
            bad++; $display("[TB] FAIL full_run_model cyc=%0d got=%b want=%b", c, obsVec(), expVec());
         end
         if (c <= 7) begin
            eRd = (c >= 1 && c <= 4); eAcc = (c >= 3 && c <= 6);
            eClr = (c == 3); eV = (c == 7);
            ex = {eRd, eAcc, eClr, eV, 1'b0, eRd ? 4'(c - 1) : 4'd0, eRd ? 2'(c - 1) : 2'd0};
            total++;
            if (obsVec() !== ex) begin
               bad++; $display("[TB] FAIL first_output_timing cyc=%0d got=%b want=%b", c, obsVec(), ex);
            end
         end
         if (valid && mReady) begin
            if (hs == 0) firstHs = c;
            else if (c - lastHs != 7) spacingErr++;
            lastHs = c; hs++;
         end
         if (done) begin dn++; doneC = c; end
         tick();
      end
      total++;
      if ({hs, dn, firstHs, doneC, spacingErr} !== {32'd13, 32'd1, 32'd7, 32'd92, 32'd0}) begin
         bad++;
         $display("[TB] FAIL full_run_summary got hs=%0d done=%0d firstHs=%0d doneCyc=%0d spacingErr=%0d want 13/1/7/92/0",
                  hs, dn, firstHs, doneC, spacingErr);
      end
   endtask

   task automatic test_backpressure();
      int cyc, bpCnt, o2;
      cyc = 0; bpCnt = 0; o2 = 0;
      start = 1'b1; mReady = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      while (!mDone && cyc < 2000) begin
         total++;
         if (obsVec() !== expVec()) begin
            bad++; $display("[TB] FAIL backpressure_model cyc=%0d got=%b want=%b", cyc, obsVec(), expVec());
         end
         if (valid && mJ == 2) o2++;
         if (mRun && mT >= M + L && mJ == 2) begin
            mReady = (bpCnt >= 5);
            bpCnt++;
         end else begin
            mReady = 1'($urandom_range(0, 1));
         end
         tick();
         cyc++;
      end
      total++;
      if (!mDone || obsVec() !== expVec()) begin
         bad++; $display("[TB] FAIL backpressure_end cyc=%0d got=%b want=%b", cyc, obsVec(), expVec());
      end
      total++;
      if (o2 != 6) begin
         bad++; $display("[TB] FAIL backpressure_hold got=%0d want=6", o2);
      end
      tick();
   endtask

   task automatic test_reset_mid_run();
      int cyc;
      cyc = 0;
      start = 1'b1; mReady = 1'b1;
      tick();
      start = 1'b0;
      while (!(mRun && mJ == 5 && mT == 2) && cyc < 500) begin
         total++;
         if (obsVec() !== expVec()) begin
            bad++; $display("[TB] FAIL pre_abort_model cyc=%0d got=%b want=%b", cyc, obsVec(), expVec());
         end
         tick();
         cyc++;
      end
      total++;
      if (!(rd && xa == 4'd7 && fa == 2'd2)) begin
         bad++; $display("[TB] FAIL abort_point got rd=%b x=%0d f=%0d want rd=1 x=7 f=2", rd, xa, fa);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if ({rd, xa, fa, clr, acc, valid, done} !== 11'd0) begin
         bad++; $display("[TB] FAIL abort_outputs got=%b want=0", {rd, xa, fa, clr, acc, valid, done});
      end
      for (int i = 0; i < L; i++) begin
         tick();
         total++;
         if (acc !== 1'b0 || obsVec() !== expVec()) begin
            bad++; $display("[TB] FAIL abort_drain i=%0d got=%b want=%b", i, obsVec(), expVec());
         end
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (!(rd && xa == 4'd0 && fa == 2'd0)) begin
         bad++; $display("[TB] FAIL restart_addr got rd=%b x=%0d f=%0d want rd=1 x=0 f=0", rd, xa, fa);
      end
      cyc = 0;
      while (!mDone && cyc < 500) begin
         tick();
         cyc++;
         total++;
         if (obsVec() !== expVec()) begin
            bad++; $display("[TB] FAIL restart_model cyc=%0d got=%b want=%b", cyc, obsVec(), expVec());
         end
      end
      tick();
   endtask

   task automatic test_start_held();
      int c, dones, doneC, firstRd2, hs2;
      c = 0; dones = 0; doneC = 0; firstRd2 = 0; hs2 = 0;
      start = 1'b1; mReady = 1'b1;
      while (dones < 2 && c < 1000) begin
         tick();
         c++;
         total++;
         if (obsVec() !== expVec()) begin
            bad++; $display("[TB] FAIL start_held_model cyc=%0d got=%b want=%b", c, obsVec(), expVec());
         end
         if (dones == 1 && valid && mReady) hs2++;
         if (dones == 1 && rd && firstRd2 == 0) firstRd2 = c;
         if (done) begin
            dones++;
            if (dones == 1) doneC = c;
            else start = 1'b0;
         end else if (dones == 1 && c >= doneC + 2) begin
            start = 1'($urandom_range(0, 1));
         end
      end
      total++;
      if (dones != 2 || firstRd2 != doneC + 2 || hs2 != 13) begin
         bad++;
         $display("[TB] FAIL start_held_rerun got dones=%0d firstRd=%0d hs=%0d want 2/%0d/13",
                  dones, firstRd2, hs2, doneC + 2);
      end
      tick(); tick();
      total++;
      if (obsVec() !== expVec() || rd !== 1'b0) begin
         bad++; $display("[TB] FAIL start_held_idle got=%b want=%b", obsVec(), expVec());
      end
   endtask

   task automatic test_param_sweep();
      logic eRd;
      logic [10:0] ex, ob;
      reset2 = 1'b0;
      tick();
      start2 = 1'b1; ready2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         eRd = (c >= 1 && c <= 8);
         ex = {eRd, (c >= 2 && c <= 9), (c == 2), (c == 10), (c == 11),
               eRd ? 3'(c - 1) : 3'd0, eRd ? 3'(c - 1) : 3'd0};
         ob = {rd2, acc2, clr2, valid2, done2, rd2 ? xa2 : 3'd0, rd2 ? fa2 : 3'd0};
         total++;
         if (ob !== ex) begin
            bad++; $display("[TB] FAIL sweep_n8m8 cyc=%0d got=%b want=%b", c, ob, ex);
         end
         tick();
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mReady = 1'b0;
      reset2 = 1'b1; start2 = 1'b0; ready2 = 1'b0;
      @(negedge clk);
      test_reset();
      test_full_run();
      test_backpressure();
      test_reset_mid_run();
      test_start_held();
      test_param_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
